score_counter: RTL and testbench

SCORE_COUNTER -- requirements
Module: score_counter

---
 rtl/score_pkg.sv | 21 ++
 rtl/bcd_digit_inc.sv | 19 +
 rtl/score_counter.sv | 123 ++++++++++++
 tb/tb_score_counter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score counter
// Contents: FSM state encoding, digit count, BCD maximum and the milestone test.
package score_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam int          SCORE_DIGITS = 4;
   localparam logic [15:0] BCD_MAX      = 16'h9999;

   // True when the lowest 'digits' BCD digits are all zero and the value is nonzero.
   function automatic logic milestone_hit(input logic [15:0] value, input int digits);
      logic [15:0] mask;
      mask = 16'((32'd1 << (4 * digits)) - 32'd1);
      return ((value & mask) == 16'd0) && (value != 16'd0);
   endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// rtl/bcd_digit_inc.sv - one BCD digit incrementer stage
// Ports: digit (current digit), carry_in (increment request),
//        digit_next (incremented digit), carry_out (9 -> 0 rollover).
module bcd_digit_inc
   import score_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       carry_in,
   output logic [3:0] digit_next,
   output logic       carry_out
);

   logic at_nine;

   assign at_nine    = (digit == 4'd9);
   assign carry_out  = carry_in & at_nine;
   assign digit_next = !carry_in ? digit : (at_nine ? 4'd0 : digit + 4'd1);

endmodule

// File: rtl/score_counter.sv
// rtl/score_counter.sv - game score counter with BCD score, milestones and high score
// Ports: clk (only clock), rst (sync active-high), score_tick (slow toggle, rising edge = 1 point),
//        gameon (play active), crash (collision level), score_bcd / hi_bcd (4-digit BCD),
//        running (state RUN), milestone (1-cycle pulse), new_high (last run beat high score).
// Build option: define SCORE_HISCORE_EN to build the high-score register and comparator.
module score_counter
   import score_pkg::*;
#(
   parameter int MILESTONE_DIGIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        score_tick,
   input  logic        gameon,
   input  logic        crash,
   output logic [15:0] score_bcd,
   output logic [15:0] hi_bcd,
   output logic        running,
   output logic        milestone,
   output logic        new_high
);

   state_t state;

   logic sync1;
   logic sync2;
   logic prev;
   logic tick_q;
   logic run_exit;

   logic [SCORE_DIGITS:0] carry;
   logic [15:0]           score_inc;

   // Synchronizer, edge register, and a registered tick event so the score
   // moves on the third clock after score_tick is first sampled high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         prev   <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         sync1  <= score_tick;
         sync2  <= sync1;
         prev   <= sync2;
         tick_q <= sync2 & ~prev;
      end
   end

   // Ripple BCD incrementer; the final carry is set only when every digit is 9.
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < SCORE_DIGITS; i++) begin : g_digit
      bcd_digit_inc u_digit (
         .digit      (score_bcd[4*i +: 4]),
         .carry_in   (carry[i]),
         .digit_next (score_inc[4*i +: 4]),
         .carry_out  (carry[i+1])
      );
   end

   assign run_exit = crash | ~gameon;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         score_bcd <= 16'h0000;
         running   <= 1'b0;
         milestone <= 1'b0;
      end else begin
         milestone <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (gameon) begin
                  state     <= ST_RUN;
                  running   <= 1'b1;
                  score_bcd <= 16'h0000;
               end
            end
            ST_RUN: begin
               // Exit has priority over a coincident tick.
               if (run_exit) begin
                  state   <= ST_OVER;
                  running <= 1'b0;
               end else if (tick_q && !carry[SCORE_DIGITS]) begin
                  score_bcd <= score_inc;
                  milestone <= milestone_hit(score_inc, MILESTONE_DIGIT);
               end
            end
            ST_OVER: begin
               if (!gameon) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

`ifdef SCORE_HISCORE_EN
   // Packed BCD orders the same as binary, so a plain unsigned compare works.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_bcd   <= 16'h0000;
         new_high <= 1'b0;
      end else if (state == ST_RUN && run_exit) begin
         new_high <= (score_bcd > hi_bcd);
         if (score_bcd > hi_bcd) begin
            hi_bcd <= score_bcd;
         end
      end else if (state == ST_OVER && !gameon) begin
         new_high <= 1'b0;
      end
   end
`else
   assign hi_bcd   = 16'h0000;
   assign new_high = 1'b0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - scoreboard bench for score_counter
module tb_score_counter;

   localparam int MD     = 2;
   localparam int MS_MOD = 10 ** MD;
`ifdef SCORE_HISCORE_EN
   localparam logic [15:0] EXP_HI = 16'h0042;
   localparam logic        EXP_NH = 1'b1;
`else
   localparam logic [15:0] EXP_HI = 16'h0000;
   localparam logic        EXP_NH = 1'b0;
`endif

   typedef struct {
      logic [15:0] score;
      logic        ms;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        score_tick = 1'b0;
   logic        gameon = 1'b0;
   logic        crash = 1'b0;
   logic [15:0] score_bcd;
   logic [15:0] hi_bcd;
   logic        running;
   logic        milestone;
   logic        new_high;

   exp_t        exp_q[$];
   int          model = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          ms_count = 0;
   int          ms_before;
   bit          mon_en = 1'b0;
   logic [15:0] last_score = 16'h0000;

   score_counter #(.MILESTONE_DIGIT(MD)) dut (
      .clk        (clk),
      .rst        (rst),
      .score_tick (score_tick),
      .gameon     (gameon),
      .crash      (crash),
      .score_bcd  (score_bcd),
      .hi_bcd     (hi_bcd),
      .running    (running),
      .milestone  (milestone),
      .new_high   (new_high)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_tick();
      if (model < 9999) begin
         model++;
         exp_q.push_back('{to_bcd(model), (model % MS_MOD) == 0});
      end
   endtask

   task automatic model_clear();
      if (model != 0) exp_q.push_back('{16'h0000, 1'b0});
      model = 0;
   endtask

   // One score_tick pulse per point; counted=0 drives ticks the DUT must ignore.
   task automatic do_ticks(input int n, input int half, input bit counted);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         score_tick = 1'b1;
         if (counted) model_tick();
         repeat (half) @(negedge clk);
         score_tick = 1'b0;
         repeat (half - 1) @(negedge clk);
      end
      repeat (6) @(negedge clk);
   endtask

   // Every score change must match the next scoreboard entry; milestone only alongside a change.
   always @(negedge clk) begin
      if (mon_en) begin
         if (milestone === 1'b1) ms_count++;
         if (score_bcd !== last_score) begin
            if (exp_q.size() == 0) begin
               check("unexpected_change", score_bcd, last_score);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_score", score_bcd, e.score);
               check("sb_milestone", milestone, e.ms);
            end
            last_score = score_bcd;
         end else if (milestone !== 1'b0) begin
            check("milestone_spurious", milestone, 1'b0);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_score", score_bcd, 16'h0000);
      check("rst_hi", hi_bcd, 16'h0000);
      check("rst_running", running, 1'b0);
      check("rst_milestone", milestone, 1'b0);
      check("rst_new_high", new_high, 1'b0);
      last_score = 16'h0000;
      mon_en = 1'b1;
      rst = 1'b0;

      // Start, first-tick latency, then to 12 and on through the 99 -> 100 milestone.
      gameon = 1'b1;
      repeat (2) @(negedge clk);
      check("run_running", running, 1'b1);
      score_tick = 1'b1;
      model_tick();
      repeat (3) @(posedge clk);
      #1 check("lat_before_e3", score_bcd, 16'h0000);
      @(posedge clk);
      #1 check("lat_at_e3", score_bcd, 16'h0001);
      @(negedge clk);
      score_tick = 1'b0;
      do_ticks(11, 4, 1'b1);
      check("score_12", score_bcd, 16'h0012);
      check("running_12", running, 1'b1);
      do_ticks(87, 2, 1'b1);
      check("score_99", score_bcd, 16'h0099);
      ms_before = ms_count;
      do_ticks(1, 2, 1'b1);
      check("score_100", score_bcd, 16'h0100);
      check("ms_pulse_once", ms_count - ms_before, 1);

      // Reset clears everything; gameon still high restarts play.
      @(negedge clk);
      model_clear();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst2_hi", hi_bcd, 16'h0000);
      repeat (2) @(negedge clk);
      check("run2_running", running, 1'b1);

      // Run to 42, then crash coincident with a tick event.
      do_ticks(42, 2, 1'b1);
      check("score_42", score_bcd, 16'h0042);
      @(negedge clk);
      score_tick = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      crash = 1'b1;
      @(negedge clk);
      check("crash_running", running, 1'b0);
      check("crash_score", score_bcd, 16'h0042);
      check("crash_hi", hi_bcd, EXP_HI);
      check("crash_new_high", new_high, EXP_NH);
      crash = 1'b0;
      score_tick = 1'b0;
      do_ticks(3, 2, 1'b0);
      check("over_hold", score_bcd, 16'h0042);
      gameon = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_new_high", new_high, 1'b0);
      check("idle_hold", score_bcd, 16'h0042);
      do_ticks(2, 2, 1'b0);
      check("idle_ignore", score_bcd, 16'h0042);

      // Second, lower run: high score must not move.
      gameon = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      do_ticks(30, 2, 1'b1);
      crash = 1'b1;
      repeat (2) @(negedge clk);
      crash = 1'b0;
      check("run3_score", score_bcd, 16'h0030);
      check("run3_hi", hi_bcd, EXP_HI);
      check("run3_new_high", new_high, 1'b0);
      gameon = 1'b0;
      repeat (2) @(negedge clk);
      gameon = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      check("restart_clear", score_bcd, 16'h0000);

      // Saturation at 9999.
      do_ticks(9998, 1, 1'b1);
      check("score_9998", score_bcd, 16'h9998);
      ms_before = ms_count;
      do_ticks(3, 2, 1'b1);
      check("score_sat", score_bcd, 16'h9999);
      check("sat_no_ms", ms_count - ms_before, 0);

      // Reset mid-run at 50.
      gameon = 1'b0;
      repeat (2) @(negedge clk);
      gameon = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      do_ticks(50, 2, 1'b1);
      check("score_50", score_bcd, 16'h0050);
      model_clear();
      rst = 1'b1;
      @(negedge clk);
      check("rst50_score", score_bcd, 16'h0000);
      check("rst50_hi", hi_bcd, 16'h0000);
      check("rst50_running", running, 1'b0);
      check("rst50_milestone", milestone, 1'b0);
      check("rst50_new_high", new_high, 1'b0);

      // A tick edge caught in the synchronizer by reset is lost.
      rst = 1'b0;
      repeat (3) @(negedge clk);
      score_tick = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      score_tick = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("inflight_lost", score_bcd, 16'h0000);
      check("inflight_running", running, 1'b1);

      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
